// File: rtl/stack_mem_responder.sv
// Memory-side responder: two requester ports (read-only port 1, read/write port 2)
// sharing one word array, with req/ack handshake, wait states and round-robin arbitration.
module stack_mem_responder #(
   parameter int DW          = 16,
   parameter int AW          = 16,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   output logic [DW-1:0] rdata1,
   output logic          ack1,
   input  logic          req2,
   input  logic          we2,
   input  logic [AW-1:0] addr2,
   input  logic [DW-1:0] wdata2,
   output logic [DW-1:0] rdata2,
   output logic          ack2,
   output logic          err,
   output logic          busy
);

   localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last2_q, last2_d;   // 1 = port 2 was served last
   logic          port2_q, port2_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic [DW-1:0] rdata2_q, rdata2_d;

   logic [DW-1:0] mem [DEPTH];
   logic          in_range;
   logic          mem_we;
   logic [DW-1:0] rd_word;

   assign in_range = ({1'b0, addr_q} < (AW+1)'(DEPTH));
   assign rd_word  = in_range ? mem[addr_q[IW-1:0]] : '0;
   assign busy     = (state_q != S_IDLE);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last2_d  = last2_q;
      port2_d  = port2_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      rdata1   = rdata1_q;
      rdata2   = rdata2_q;
      ack1     = 1'b0;
      ack2     = 1'b0;
      err      = 1'b0;
      mem_we   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req1 || req2) begin
               port2_d = req2 && (!req1 || !last2_q);
               addr_d  = port2_d ? addr2 : addr1;
               we_d    = port2_d && we2;
               wdata_d = wdata2;
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
               end else begin
                  cnt_d   = WS_LOAD;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_ACK;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACK: begin
            state_d = S_IDLE;
            last2_d = port2_q;
            err     = !in_range;
            mem_we  = we_q && in_range;
            if (port2_q) begin
               ack2 = 1'b1;
               // Writes leave rdata2 alone unless the address was out of range.
               if (!we_q || !in_range) rdata2 = rd_word;
               rdata2_d = rdata2;
            end else begin
               ack1     = 1'b1;
               rdata1   = rd_word;
               rdata1_d = rdata1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         last2_q  <= 1'b1;
         port2_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last2_q  <= last2_d;
         port2_q  <= port2_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

   // NOTE: the array has no reset; gating the write with rst drops a write caught by reset.
   always_ff @(posedge clk) begin
      if (rst && mem_we) mem[addr_q[IW-1:0]] <= wdata_q;
   end

endmodule
